// File: rtl/cordic_sequencer.sv
// Sequences one sin/cos evaluation: normalizer -> CORDIC core -> converter -> output handshake.
// The core is watched by a timeout counter; an expired wait pulses err and abandons the op.
module cordic_sequencer #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ang_in,
    input  logic             ang_valid,
    output logic             ang_ready,
    output logic [WIDTH-1:0] norm_ang_out,
    input  logic [WIDTH-1:0] norm_ang_in,
    input  logic [2:0]       norm_flip_in,
    output logic             cordic_start,
    output logic [WIDTH-1:0] cordic_ang,
    input  logic             cordic_done,
    output logic [2:0]       conv_flip,
    input  logic [WIDTH-1:0] conv_sin_in,
    input  logic [WIDTH-1:0] conv_cos_in,
    output logic [WIDTH-1:0] res_sin,
    output logic [WIDTH-1:0] res_cos,
    output logic [2:0]       res_flip,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic             err
);

    // state  | meaning
    // IDLE   | waiting for an angle, ang_ready high
    // NORM   | normalizer output sampled into cordic_ang / conv_flip
    // START  | one-cycle start pulse to the core, timeout counter cleared
    // WAIT   | waiting for cordic_done or timeout
    // OUT    | result presented until res_ready
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NORM  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic             w_timeout;
    logic [WIDTH-1:0] r_norm_ang;
    logic [WIDTH-1:0] r_cordic_ang;
    logic [2:0]       r_conv_flip;
    logic [WIDTH-1:0] r_res_sin;
    logic [WIDTH-1:0] r_res_cos;
    logic [2:0]       r_res_flip;
    logic             r_err;

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE:  if (ang_valid) w_next = S_NORM;
            S_NORM:  w_next = S_START;
            S_START: w_next = S_WAIT;
            S_WAIT: begin
                // done takes priority over a timeout landing in the same cycle
                if (cordic_done) begin
                    w_next = S_OUT;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_OUT:   if (res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_norm_ang   <= '0;
            r_cordic_ang <= '0;
            r_conv_flip  <= '0;
            r_res_sin    <= '0;
            r_res_cos    <= '0;
            r_res_flip   <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_timeout;
            case (r_state)
                S_IDLE: if (ang_valid) r_norm_ang <= ang_in;
                S_NORM: begin
                    r_cordic_ang <= norm_ang_in;
                    r_conv_flip  <= norm_flip_in;
                end
                S_START: r_cnt <= '0;
                S_WAIT: begin
                    if (cordic_done) begin
                        r_res_sin  <= conv_sin_in;
                        r_res_cos  <= conv_cos_in;
                        r_res_flip <= r_conv_flip;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ang_ready    = rst && (r_state == S_IDLE);
    assign cordic_start = (r_state == S_START);
    assign res_valid    = (r_state == S_OUT);
    assign busy         = (r_state != S_IDLE);
    assign err          = r_err;
    assign norm_ang_out = r_norm_ang;
    assign cordic_ang   = r_cordic_ang;
    assign conv_flip    = r_conv_flip;
    assign res_sin      = r_res_sin;
    assign res_cos      = r_res_cos;
    assign res_flip     = r_res_flip;

endmodule
